// File: rtl/load_store_unit.sv
// Data-memory load/store initiator: pipeline valid/ready in, variable-latency req/ack memory bus out.
// Handles alignment checking, byte-lane steering, load extension and the request timeout.
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`define DM_OP_WD  3'd0
`define DM_OP_UH  3'd1
`define DM_OP_SH  3'd2
`define DM_OP_UB  3'd3
`define DM_OP_SB  3'd4
`endif

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [`DM_OP_BIT-1:0] req_op,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t                state_q;
  logic [7:0]            tmo_q;
  logic                  we_q;
  logic [`DM_OP_BIT-1:0] op_q;
  logic [1:0]            lane_q;

  logic                  req_ready_q, busy_q;
  logic                  mem_req_q, mem_we_q;
  logic [31:0]           mem_addr_q, mem_wdata_q;
  logic [3:0]            mem_be_q;
  logic                  resp_valid_q, resp_err_q;
  logic [31:0]           resp_rdata_q;

  logic                  legal_d;
  logic [3:0]            be_d;
  logic [31:0]           wdata_d;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;
  logic [31:0]           load_d;

  // Request decode: legality, lane enables and replicated store data.
  always_comb begin
    legal_d = 1'b0;
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    case (req_op)
      `DM_OP_WD: begin
        legal_d = (req_addr[1:0] == 2'b00);
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
      `DM_OP_UH, `DM_OP_SH: begin
        legal_d = ~req_addr[0];
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      `DM_OP_UB, `DM_OP_SB: begin
        legal_d = 1'b1;
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      default: legal_d = 1'b0;
    endcase
    if (!req_we) wdata_d = 32'h0;
  end

  always_comb begin
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    load_d   = 32'h0;
    case (op_q)
      `DM_OP_WD: load_d = mem_rdata;
      `DM_OP_UH: load_d = {16'h0, half_sel};
      `DM_OP_SH: load_d = {{16{half_sel[15]}}, half_sel};
      `DM_OP_UB: load_d = {24'h0, byte_sel};
      `DM_OP_SB: load_d = {{24{byte_sel[7]}}, byte_sel};
      default:   load_d = 32'h0;
    endcase
    if (we_q) load_d = 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tmo_q        <= 8'd0;
      we_q         <= 1'b0;
      op_q         <= '0;
      lane_q       <= 2'b00;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            op_q        <= req_op;
            lane_q      <= req_addr[1:0];
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (legal_d) begin
              state_q     <= S_ISSUE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // An ack on the final timeout edge still completes the access cleanly.
          if (mem_ack || tmo_q == TMO_LAST) begin
            state_q      <= S_RESP;
            tmo_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ~mem_ack;
            resp_rdata_q <= mem_ack ? load_d : 32'h0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/idle sequences and
// randomized accesses checked against a byte-level reference model.
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`define DM_OP_WD  3'd0
`define DM_OP_UH  3'd1
`define DM_OP_SH  3'd2
`define DM_OP_UB  3'd3
`define DM_OP_SB  3'd4
`endif

module tb_load_store_unit;
  localparam int TMO = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr, wdata, memword;
    int          dly;     // ack raised in ISSUE cycle dly+1; -1 = never
    logic        issue, err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          noisy;   // keep req_valid high with other data while busy
  } vec_t;

  // Reference model: sizes, offsets and byte arithmetic straight from the access rules.
  task automatic model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] memword, input int dly,
                       output logic issue, output logic err, output logic [31:0] rdata,
                       output logic [3:0] be, output logic [31:0] wd);
    int    size, off;
    bit    sgn;
    longint v;
    size = 0; sgn = 0;
    case (op)
      `DM_OP_WD: size = 4;
      `DM_OP_UH: size = 2;
      `DM_OP_SH: begin size = 2; sgn = 1; end
      `DM_OP_UB: size = 1;
      `DM_OP_SB: begin size = 1; sgn = 1; end
      default:   size = 0;
    endcase
    off   = int'(addr % 4);
    issue = (size != 0) && (off % size == 0);
    be    = issue ? 4'(((1 << size) - 1) << off) : 4'h0;
    wd    = 32'h0;
    if (issue && we)
      for (int b = 0; b < 4; b++) wd[8*b +: 8] = wdata[8*(b % size) +: 8];
    err   = !issue || dly < 0 || dly >= TMO;
    rdata = 32'h0;
    if (!err && !we) begin
      v = longint'({32'h0, memword}) >> (8 * off);
      v = v & ((64'd1 << (8 * size)) - 1);
      if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
      rdata = 32'(v);
    end
  endtask

  task automatic run_access(input string nm, input vec_t t);
    bit acked;
    @(negedge clk);
    chk({nm, " ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = t.we; req_op = t.op; req_addr = t.addr; req_wdata = t.wdata;
    @(negedge clk);
    req_valid = t.noisy && t.issue;
    req_addr  = ~t.addr; req_wdata = ~t.wdata; req_we = ~t.we;
    acked = 0;
    if (t.issue) begin
      for (int k = 1; k <= TMO && !acked; k++) begin
        chk({nm, " mem_req"},    {31'h0, mem_req},    32'd1);
        chk({nm, " mem_we"},     {31'h0, mem_we},     {31'h0, t.we});
        chk({nm, " mem_addr"},   mem_addr,            t.addr & 32'hFFFF_FFFC);
        chk({nm, " mem_be"},     {28'h0, mem_be},     {28'h0, t.be});
        chk({nm, " mem_wdata"},  mem_wdata,           t.wd);
        chk({nm, " busy/ready"}, {30'h0, busy, req_ready}, 32'd2);
        chk({nm, " early resp"}, {31'h0, resp_valid}, 32'd0);
        if (t.dly == k - 1) begin
          mem_ack = 1'b1; mem_rdata = t.memword; req_valid = 1'b0; acked = 1;
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk({nm, " resp_valid"}, {31'h0, resp_valid}, 32'd1);
    chk({nm, " resp_err"},   {31'h0, resp_err},   {31'h0, t.err});
    chk({nm, " resp_rdata"}, resp_rdata,          t.rdata);
    chk({nm, " req dropped"}, {30'h0, mem_req, busy}, 32'd1);
    @(negedge clk);
    chk({nm, " pulse end"}, {29'h0, resp_valid, busy, req_ready}, 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    vec_t r;
    // {we, op, addr, wdata, memword, dly, issue, err, rdata, be, wd, noisy}
    vecs[0]  = '{1'b1, `DM_OP_WD, 32'h10, 32'hDEADBEEF, 32'h0,          0, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF, 0};
    vecs[1]  = '{1'b0, `DM_OP_SB, 32'h07, 32'h0,        32'h80FF_0000,  0, 1'b1, 1'b0, 32'hFFFFFF80, 4'b1000, 32'h0,        0};
    vecs[2]  = '{1'b0, `DM_OP_UB, 32'h07, 32'h0,        32'h80FF_0000,  1, 1'b1, 1'b0, 32'h00000080, 4'b1000, 32'h0,        0};
    vecs[3]  = '{1'b1, `DM_OP_UH, 32'h22, 32'h1234ABCD, 32'h0,          0, 1'b1, 1'b0, 32'h0,        4'b1100, 32'hABCDABCD, 0};
    vecs[4]  = '{1'b0, `DM_OP_SH, 32'h03, 32'h0,        32'h0,          0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        0};
    vecs[5]  = '{1'b0, `DM_OP_WD, 32'h44, 32'h0,        32'hCAFEF00D,   5, 1'b1, 1'b0, 32'hCAFEF00D, 4'b1111, 32'h0,        1};
    vecs[6]  = '{1'b0, `DM_OP_WD, 32'h40, 32'h0,        32'h12345678,  -1, 1'b1, 1'b1, 32'h0,        4'b1111, 32'h0,        0};
    vecs[7]  = '{1'b0, `DM_OP_SH, 32'h42, 32'h0,        32'h8001_7FFF, TMO-1, 1'b1, 1'b0, 32'hFFFF8001, 4'b1100, 32'h0,   0};
    vecs[8]  = '{1'b0, `DM_OP_UH, 32'h40, 32'h0,        32'h8001_7FFF,  2, 1'b1, 1'b0, 32'h00007FFF, 4'b0011, 32'h0,        0};
    vecs[9]  = '{1'b1, `DM_OP_SB, 32'h05, 32'h000000A5, 32'h0,          0, 1'b1, 1'b0, 32'h0,        4'b0010, 32'hA5A5A5A5, 0};
    vecs[10] = '{1'b1, 3'd7,      32'h08, 32'h1,        32'h0,          0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        0};
    vecs[11] = '{1'b0, `DM_OP_WD, 32'h02, 32'h0,        32'h0,          0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        0};

    #1 rst_n = 1'b0;
    #2;
    chk("reset ready/busy", {30'h0, req_ready, busy}, 32'd2);
    chk("reset mem_req/we", {30'h0, mem_req, mem_we}, 32'd0);
    chk("reset resp", {30'h0, resp_valid, resp_err}, 32'd0);
    chk("reset rdata|addr|wdata|be", resp_rdata | mem_addr | mem_wdata | {28'h0, mem_be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stray ack while idle must do nothing.
    mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle ack ignored", {29'h0, resp_valid, mem_req, busy}, 32'd0);
    end
    mem_ack = 1'b0;

    for (int i = 0; i < 12; i++) run_access($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of ISSUE abandons the access without a response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = `DM_OP_WD; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst seq mem_req up", {31'h0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst async mem_req", {31'h0, mem_req}, 32'd0);
    chk("rst async ready/busy", {30'h0, req_ready, busy}, 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post-rst quiet", {29'h0, resp_valid, mem_req, req_ready}, 32'd1);
    end
    run_access("post-rst access", vecs[0]);

    for (int i = 0; i < 60; i++) begin
      r.we = 1'($urandom);
      r.op = ($urandom % 8 != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      r.addr = $urandom;
      if ($urandom % 2 == 0) r.addr = r.addr & 32'hFFFF_FFFC;
      r.wdata = $urandom;
      r.memword = $urandom;
      r.dly = $urandom_range(0, TMO);
      if (r.dly == TMO) r.dly = -1;
      r.noisy = 1'($urandom);
      model(r.we, r.op, r.addr, r.wdata, r.memword, r.dly, r.issue, r.err, r.rdata, r.be, r.wd);
      run_access($sformatf("rnd%0d", i), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
